// File: rtl/ahb_slave_arbiter_if.sv
// Bus-side signals seen by one per-slave arbiter: per-master request
// qualifiers in, address/data-phase ownership out.
interface ahb_slave_arbiter_if #(
    parameter int unsigned NO_OF_MASTERS = 4,
    parameter int unsigned ID_W          = $clog2(NO_OF_MASTERS)
);
    logic [NO_OF_MASTERS-1:0]   req;
    logic [NO_OF_MASTERS-1:0]   lock;
    logic [2*NO_OF_MASTERS-1:0] htrans;
    logic                       hready;
    logic [NO_OF_MASTERS-1:0]   grant;
    logic [ID_W-1:0]            addr_owner;
    logic                       owner_valid;
    logic [ID_W-1:0]            data_owner;
    logic                       data_valid;

    // Interconnect side: drives requests, consumes ownership.
    modport master (
        output req, lock, htrans, hready,
        input  grant, addr_owner, owner_valid, data_owner, data_valid
    );

    // Arbiter side.
    modport slave (
        input  req, lock, htrans, hready,
        output grant, addr_owner, owner_valid, data_owner, data_valid
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin with lock priority, grant held for
// whole bursts and locked sequences, plus data-phase owner tracking.
module ahb_slave_arbiter #(
    parameter int unsigned NO_OF_MASTERS = 4,
    parameter int unsigned ID_W          = $clog2(NO_OF_MASTERS)
) (
    input  logic hclk,
    input  logic hresetn,
    ahb_slave_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [NO_OF_MASTERS-1:0] grant, grant_nxt;
    logic [ID_W-1:0]          addr_owner, owner_nxt;
    logic                     owner_valid, valid_nxt;
    logic [ID_W-1:0]          data_owner;
    logic                     data_valid;
    logic [ID_W-1:0]          rr_ptr, rr_nxt;

    logic                     owner_req;
    logic                     owner_lock;
    logic [1:0]               owner_trans;

    logic                     sel_valid;
    logic                     sel_locked;
    logic [ID_W-1:0]          sel_pick;
    logic                     lock_found, req_found;
    logic [ID_W-1:0]          lock_pick, req_pick;
    logic                     arbitrate;

    // Extract the current address owner's request, lock and htrans.
    always_comb begin
        owner_req   = 1'b0;
        owner_lock  = 1'b0;
        owner_trans = 2'b00;
        for (int unsigned m = 0; m < NO_OF_MASTERS; m++) begin
            if (addr_owner == ID_W'(m)) begin
                owner_req   = bus.req[m];
                owner_lock  = bus.lock[m];
                owner_trans = bus.htrans[2*m +: 2];
            end
        end
    end

    // Round-robin scan from rr_ptr; locked requesters take precedence.
    // Index wraps by subtraction so non-power-of-2 counts work.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        lock_found = 1'b0;
        req_found  = 1'b0;
        lock_pick  = '0;
        req_pick   = '0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NO_OF_MASTERS) begin
                idx = idx - NO_OF_MASTERS;
            end
            idx_w = ID_W'(idx);
            if (!lock_found && bus.req[idx_w] && bus.lock[idx_w]) begin
                lock_found = 1'b1;
                lock_pick  = idx_w;
            end
            if (!req_found && bus.req[idx_w]) begin
                req_found = 1'b1;
                req_pick  = idx_w;
            end
        end
        sel_valid  = req_found;
        sel_locked = lock_found;
        sel_pick   = lock_found ? lock_pick : req_pick;
    end

    // Next-state and next-grant: decide whether this edge is an
    // arbitration point, then either hold, hand over, or go idle.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = addr_owner;
        valid_nxt = owner_valid;
        rr_nxt    = rr_ptr;
        arbitrate = 1'b0;

        unique case (state)
            IDLE:    arbitrate = 1'b1;
            // htrans[0]=1 is SEQ or BUSY, i.e. mid-burst.
            GRANTED: arbitrate = !(owner_req && owner_trans[0]);
            LOCKED:  arbitrate = !owner_lock && (owner_trans == 2'b00);
            default: arbitrate = 1'b1;
        endcase

        if (arbitrate) begin
            if (sel_valid) begin
                state_nxt = sel_locked ? LOCKED : GRANTED;
                for (int unsigned m = 0; m < NO_OF_MASTERS; m++) begin
                    grant_nxt[m] = (sel_pick == ID_W'(m));
                end
                owner_nxt = sel_pick;
                valid_nxt = 1'b1;
                rr_nxt    = (sel_pick == ID_W'(NO_OF_MASTERS - 1)) ? '0
                                                                  : sel_pick + ID_W'(1);
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
            end
        end
    end

    // State, ownership and data-phase registers; advance only on hready.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= IDLE;
            grant       <= '0;
            addr_owner  <= '0;
            owner_valid <= 1'b0;
            data_owner  <= '0;
            data_valid  <= 1'b0;
            rr_ptr      <= '0;
        end else if (bus.hready) begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            addr_owner  <= owner_nxt;
            owner_valid <= valid_nxt;
            data_owner  <= addr_owner;
            data_valid  <= owner_valid & owner_trans[1];
            rr_ptr      <= rr_nxt;
        end
    end

    assign bus.grant       = grant;
    assign bus.addr_owner  = addr_owner;
    assign bus.owner_valid = owner_valid;
    assign bus.data_owner  = data_owner;
    assign bus.data_valid  = data_valid;

endmodule
